button_event_ctrl: RTL and testbench
====================================

// Module: button_event_ctrl
// PURPOSE
//  Button front-end controller: syncs and debounces one raw pushbutton, then sequences the clean
//  level through a press FSM. Emits one-cycle press, release, long-press and auto-repeat events.
//  Sits between a board pin and user-interface logic (menu, counter, mode-select FSMs).
// PARAMETERS
//  DB_CYCLES     16   consecutive stable cycles required before the debounced level changes (>=2)
//  LONG_CYCLES   100  cycles sigOut must stay high after press before longPls (> DB_CYCLES)
//  REPEAT_CYCLES 20   auto-repeat period in LONG state (used only with BTN_REPEAT_EN, >=2)
//  CW            16   counter width; 2**CW-1 >= max(DB_CYCLES, LONG_CYCLES, REPEAT_CYCLES)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  asynchronous, active-low reset
//  sigIn      in   1  raw, asynchronous, bouncing button input (1 = pressed)
//  en         in   1  event enable; debounce runs regardless
//  sigOut     out  1  debounced level
//  pressPls   out  1  one-cycle pulse on accepted press
//  releasePls out  1  one-cycle pulse on accepted release
//  longPls    out  1  one-cycle pulse when press held LONG_CYCLES
//  repeatPls  out  1  one-cycle auto-repeat pulse (constant 0 without BTN_REPEAT_EN)
//  busy       out  1  high in HELD or LONG
// BEHAVIOUR
//  Reset (rst=0, async): sync FFs, sigOut, all pulses, busy, counters = 0; FSM = IDLE.
//  Sync: 2-FF synchronizer sigIn -> syncIn; no other logic sees sigIn.
//  Debounce: dbCnt clears whenever syncIn==sigOut; else increments. When it would reach
//   DB_CYCLES, sigOut toggles and dbCnt clears. Latency: clean sigIn edge -> sigOut edge = 2+DB_CYCLES clks.
//   Any return of syncIn to sigOut before DB_CYCLES restarts the count (glitch rejected).
//  Pulses are registered and rise on the same edge as the sigOut change or counter event causing them;
//   high exactly 1 clk; at most one of press/release/long/repeat high in any cycle.
//  FSM states: IDLE, HELD, LONG, WAIT_REL. holdCnt clears on every state entry.
//   IDLE:     sigOut 0->1 & en=1 -> HELD, pressPls. sigOut 0->1 & en=0 -> WAIT_REL, no pulse.
//   HELD:     holdCnt++ each clk. sigOut 1->0 -> IDLE, releasePls.
//             holdCnt reaches LONG_CYCLES-1 (longPls exactly LONG_CYCLES clks after pressPls) -> LONG, longPls.
//   LONG:     holdCnt++ each clk, wraps to 0 at REPEAT_CYCLES-1. sigOut 1->0 -> IDLE, releasePls.
//   WAIT_REL: no pulses; sigOut 1->0 -> IDLE, no releasePls.
//   en=0 in HELD/LONG -> WAIT_REL next clk, no releasePls. en=0 & sigOut 1->0 same clk -> IDLE, no pulse.
//   Release and long boundary same clk: release wins (releasePls, no longPls).
//  busy = (state==HELD)|(state==LONG), registered.
//  Reset mid-hold: all outputs drop at once; after rst=1 with sigIn=1, sigOut rises after
//   2+DB_CYCLES clks and a fresh pressPls fires if en=1.
//  holdCnt never overflows: compared against LONG_CYCLES-1 in HELD, cleared on LONG entry.
// CONFIGURATION
//  BTN_REPEAT_EN defined: in LONG, repeatPls on every holdCnt wrap; first repeat REPEAT_CYCLES
//   clks after longPls, then every REPEAT_CYCLES; none on/after release cycle.
//  BTN_REPEAT_EN undefined: repeatPls tied 0, LONG wrap logic and REPEAT_CYCLES unused; LONG holds to release.
// TESTING (DB_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=5, 10 ns clk)
//  1 Bounce: sigIn toggles every 1 ns for 21 ns ending at 1, en=1 -> sigOut rises 6 clks after last edge;
//    exactly one pressPls, coincident with sigOut rise.
//  2 Glitch: sigIn high for 3 clks then low -> sigOut stays 0; no pulses; dbCnt back to 0.
//  3 Long hold 30 clks -> pressPls at t0, longPls at t0+10; with BTN_REPEAT_EN repeatPls at t0+15,
//    t0+20, ...; without macro repeatPls never; release -> single releasePls, busy 0 next clk.
//  4 Enable: en=0 at t0+5 of hold -> busy 0, no releasePls on release; en=1 while held -> no pressPls
//    until release and re-press.
//  5 Reset: rst=0 mid-LONG -> all outputs 0 immediately; rst=1 with sigIn=1 -> sigOut and pressPls 6 clks later.
//  6 Short press 5 clks after sigOut rise -> pressPls then releasePls; no longPls, no repeatPls.

Source files
------------

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: 2-FF sync, debounce and press FSM for one pushbutton.
// Define BTN_REPEAT_EN to enable auto-repeat pulses in the LONG state.
`timescale 1ns/1ps
module button_event_ctrl #(
    parameter int DB_CYCLES     = 16,
    parameter int LONG_CYCLES   = 100,
    parameter int REPEAT_CYCLES = 20,
    parameter int CW            = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sigIn,
    input  logic en,
    output logic sigOut,
    output logic pressPls,
    output logic releasePls,
    output logic longPls,
    output logic repeatPls,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG,
        WAIT_REL
    } state_t;

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

    logic          sync_q1;
    logic          sync_in;
    logic [CW-1:0] db_cnt;
    logic          db_flip;
    logic          rise_ev;
    logic          fall_ev;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_d;
    logic          press_d;
    logic          release_d;
    logic          long_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_in <= 1'b0;
        end else begin
            sync_q1 <= sigIn;
            sync_in <= sync_q1;
        end
    end

    // Edge events fire on the same edge sigOut changes
    assign db_flip = (sync_in != sigOut) && (db_cnt == DB_LAST);
    assign rise_ev = db_flip && !sigOut;
    assign fall_ev = db_flip && sigOut;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt <= '0;
            sigOut <= 1'b0;
        end else begin
            if ((sync_in == sigOut) || db_flip) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            sigOut <= sigOut ^ db_flip;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
    logic repeat_d;
`else
    logic unused_rep;
    assign unused_rep = REPEAT_CYCLES[0];
`endif

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_cnt + 1'b1;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
`ifdef BTN_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (rise_ev) begin
                    state_d = en ? HELD : WAIT_REL;
                    press_d = en;
                end
            end
            HELD: begin
                if (fall_ev) begin
                    state_d   = IDLE;
                    release_d = en;
                end else if (!en) begin
                    state_d = WAIT_REL;
                end else if (hold_cnt == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end
            LONG: begin
`ifdef BTN_REPEAT_EN
                if (hold_cnt == REP_LAST) begin
                    hold_d = '0;
                end
`else
                hold_d = '0;
`endif
                if (fall_ev) begin
                    state_d   = IDLE;
                    release_d = en;
                end else if (!en) begin
                    state_d = WAIT_REL;
`ifdef BTN_REPEAT_EN
                end else if (hold_cnt == REP_LAST) begin
                    repeat_d = 1'b1;
`endif
                end
            end
            WAIT_REL: begin
                if (fall_ev) begin
                    state_d = IDLE;
                end
            end
        endcase
        // Counter restarts on every state entry; idle states keep it at zero
        if ((state_d != state_q) || (state_q == IDLE) || (state_q == WAIT_REL)) begin
            hold_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold_cnt   <= '0;
            pressPls   <= 1'b0;
            releasePls <= 1'b0;
            longPls    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt   <= hold_d;
            pressPls   <= press_d;
            releasePls <= release_d;
            longPls    <= long_d;
            busy       <= (state_d == HELD) || (state_d == LONG);
        end
    end

`ifdef BTN_REPEAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            repeatPls <= 1'b0;
        end else begin
            repeatPls <= repeat_d;
        end
    end
`else
    assign repeatPls = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: directed vector table plus hand sequences
// for bounce, long hold, repeat and mid-hold reset.
`timescale 1ns/1ps
module tb_button_event_ctrl;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic sigIn = 1'b0;
    logic en    = 1'b1;
    logic sigOut, pressPls, releasePls, longPls, repeatPls, busy;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef BTN_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    button_event_ctrl #(
        .DB_CYCLES(4),
        .LONG_CYCLES(10),
        .REPEAT_CYCLES(5),
        .CW(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sigIn(sigIn),
        .en(en),
        .sigOut(sigOut),
        .pressPls(pressPls),
        .releasePls(releasePls),
        .longPls(longPls),
        .repeatPls(repeatPls),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // bits = {si, en, so, press, release, long, busy}
    typedef struct {
        logic [6:0] bits;
        int         n;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [6:0] bits, input int n);
        vec_t v;
        v.bits = bits;
        v.n    = n;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic so, input logic pr,
                            input logic rl, input logic lg, input logic rp,
                            input logic bz);
        chk({tag, ".sigOut"}, sigOut, so);
        chk({tag, ".press"}, pressPls, pr);
        chk({tag, ".release"}, releasePls, rl);
        chk({tag, ".long"}, longPls, lg);
        chk({tag, ".repeat"}, repeatPls, rp);
        chk({tag, ".busy"}, busy, bz);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int rise_c;
        int press_c;
        int npress;
        int nrel;

        #12;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // idle, then glitch of 3 clks
        add(7'b01_00000, 2);
        add(7'b11_00000, 3);
        add(7'b01_00000, 4);
        // short press
        add(7'b11_00000, 5);
        add(7'b11_11001, 1);
        add(7'b01_10001, 5);
        add(7'b01_00100, 1);
        add(7'b01_00000, 2);
        // release on the long boundary: release wins
        add(7'b11_00000, 5);
        add(7'b11_11001, 1);
        add(7'b11_10001, 4);
        add(7'b01_10001, 5);
        add(7'b01_00100, 1);
        add(7'b01_00000, 2);
        // en drops mid-hold, re-enabled while held
        add(7'b11_00000, 5);
        add(7'b11_11001, 1);
        add(7'b11_10001, 4);
        add(7'b10_10000, 1);
        add(7'b11_10000, 12);
        add(7'b01_10000, 5);
        add(7'b01_00000, 3);
        // re-press after release
        add(7'b11_00000, 5);
        add(7'b11_11001, 1);
        add(7'b01_10001, 5);
        add(7'b01_00100, 1);
        add(7'b01_00000, 2);
        // en=0 together with release
        add(7'b11_00000, 5);
        add(7'b11_11001, 1);
        add(7'b01_10001, 5);
        add(7'b00_00000, 1);
        add(7'b01_00000, 2);
        // press while disabled goes to WAIT_REL
        add(7'b10_00000, 5);
        add(7'b10_10000, 1);
        add(7'b11_10000, 3);
        add(7'b01_10000, 5);
        add(7'b01_00000, 3);

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                sigIn = tbl[i].bits[6];
                en    = tbl[i].bits[5];
                step();
                chk_outs($sformatf("vec%0d.%0d", i, c), tbl[i].bits[4],
                         tbl[i].bits[3], tbl[i].bits[2], tbl[i].bits[1],
                         1'b0, tbl[i].bits[0]);
            end
        end

        // bounce: 21 toggles 1 ns apart, ending high
        en = 1'b1;
        @(posedge clk);
        #0.5;
        for (int i = 0; i < 21; i++) begin
            sigIn = ~sigIn;
            if (i < 20) #1;
        end
        rise_c  = 0;
        press_c = 0;
        npress  = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (sigOut && rise_c == 0) rise_c = c;
            if (pressPls) begin
                npress++;
                press_c = c;
            end
        end
        chk_int("bounce.rise_clk", rise_c, 6);
        chk_int("bounce.press_cnt", npress, 1);
        chk_int("bounce.press_clk", press_c, 6);
        sigIn = 1'b0;
        nrel  = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (releasePls) nrel++;
        end
        chk_int("bounce.release_cnt", nrel, 1);

        // long hold with optional repeat, release on a repeat boundary
        sigIn = 1'b1;
        t = 0;
        for (int c = 1; c <= 10 && t == 0; c++) begin
            step();
            if (pressPls) t = c;
        end
        chk_int("long.press_lat", t, 6);
        for (int k = 1; k <= 41; k++) begin
            if (k == 35) sigIn = 1'b0;
            step();
            chk_outs($sformatf("long.k%0d", k), k < 40, 1'b0, k == 40,
                     k == 10,
                     REP_ON && k > 10 && k < 40 && ((k - 10) % 5 == 0),
                     k < 40);
        end

        // reset in LONG, then restart with the button still held
        sigIn = 1'b1;
        for (int c = 1; c <= 18; c++) step();
        chk("rst.pre_busy", busy, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk_outs("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk_outs($sformatf("rst.k%0d", k), k >= 6, k == 6, 1'b0, 1'b0,
                     1'b0, k >= 6);
        end
        sigIn = 1'b0;
        nrel  = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (releasePls) nrel++;
        end
        chk_int("rst.release_cnt", nrel, 1);
        chk("rst.end_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
